branch_redirect: RTL and testbench

//   Fetch-PC owner and branch resolution stage, directly downstream of BranchCompare.

---
 rtl/branch_redirect.sv | 147 ++++++++++++++
 tb/tb_branch_redirect.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect.sv
// Fetch-PC owner and branch resolution: computes control-transfer targets, redirects fetch,
// drives a timed flush of the two younger stages, traps misaligned targets, counts branches.
module branch_redirect #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic             bc_out,
  output logic [31:0]      pc,
  output logic             redirect,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned FCNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_TRAP
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              flush_q, flush_d;
  logic              misalign_q, misalign_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  logic              take_c;
  logic              is_cond_c;
  logic [XLEN-1:0]   target_c;
  logic [XLEN-1:0]   pc_inc_c;

  // Target and take decode; jalr wins over jal/branch, which share the pc-relative target.
  always_comb begin
    is_cond_c = ex_valid & ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
    take_c    = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & bc_out));
    if (ex_is_jalr) begin
      target_c = XLEN'(ex_rs1 + ex_imm) & ~XLEN'(1);
    end else begin
      target_c = XLEN'(ex_pc + ex_imm);
    end
    pc_inc_c = XLEN'(pc_q + XLEN'(4));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = 1'b0;
    flush_d      = flush_q;
    misalign_d   = misalign_q;
    fcnt_d       = fcnt_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;

    unique case (state_q)
      ST_RUN: begin
        flush_d = 1'b0;
        if (take_c) begin
          flush_d = 1'b1;
          if (target_c[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ST_TRAP;
          end else begin
            pc_d       = target_c;
            redirect_d = 1'b1;
            fcnt_d     = FCNT_W'(FLUSH_CYCLES - 1);
            state_d    = ST_FLUSH;
          end
        end else if (!stall) begin
          pc_d = pc_inc_c;
        end
        if (is_cond_c) begin
          if (branch_cnt_q != '1) branch_cnt_d = CNT_W'(branch_cnt_q + CNT_W'(1));
          if (bc_out && (taken_cnt_q != '1)) taken_cnt_d = CNT_W'(taken_cnt_q + CNT_W'(1));
        end
      end
      ST_FLUSH: begin
        if (!stall) pc_d = pc_inc_c;
        // The flush window runs on wall-clock cycles, independent of stall.
        if (fcnt_q != '0) begin
          fcnt_d  = FCNT_W'(fcnt_q - FCNT_W'(1));
          flush_d = 1'b1;
        end else begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_TRAP: begin
        flush_d    = 1'b1;
        misalign_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      redirect_q   <= 1'b0;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
      fcnt_q       <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      flush_q      <= flush_d;
      misalign_q   <= misalign_d;
      fcnt_q       <= fcnt_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign redirect     = redirect_q;
  assign flush_ifid   = flush_q;
  assign flush_idex   = flush_q;
  assign misalign_exc = misalign_q;
  assign branch_cnt   = branch_cnt_q;
  assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Scoreboard bench for branch_redirect: driver queues hand-computed expectations per cycle,
// monitor pops one entry after every rising edge and compares all outputs.
module tb_branch_redirect;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_imm;
  logic [31:0]      ex_rs1;
  logic             bc_out;
  logic [31:0]      pc;
  logic             redirect;
  logic             flush_ifid;
  logic             flush_idex;
  logic             misalign_exc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  branch_redirect #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_is_jal   (ex_is_jal),
    .ex_is_jalr  (ex_is_jalr),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .bc_out      (bc_out),
    .pc          (pc),
    .redirect    (redirect),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .misalign_exc(misalign_exc),
    .branch_cnt  (branch_cnt),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic             rd;
    logic             fl;
    logic             mis;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] tc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  e;
  string nm;

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (pc !== e.pc || redirect !== e.rd || flush_ifid !== e.fl || flush_idex !== e.fl ||
          misalign_exc !== e.mis || branch_cnt !== e.bc || taken_cnt !== e.tc) begin
        errors++;
        $display("FAIL %s: got pc=%h rd=%b fi=%b fe=%b mis=%b bc=%0d tc=%0d, want pc=%h rd=%b fl=%b mis=%b bc=%0d tc=%0d",
                 nm, pc, redirect, flush_ifid, flush_idex, misalign_exc, branch_cnt, taken_cnt,
                 e.pc, e.rd, e.fl, e.mis, e.bc, e.tc);
      end
    end
  end

  task automatic set_ex(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic bco, input logic [31:0] p, input logic [31:0] imm,
                        input logic [31:0] rs1);
    ex_valid     = v;
    ex_is_branch = br;
    ex_is_jal    = jal;
    ex_is_jalr   = jalr;
    bc_out       = bco;
    ex_pc        = p;
    ex_imm       = imm;
    ex_rs1       = rs1;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // Queue the expectation for the coming edge, then return at the following falling edge.
  task automatic cyc(input string n, input logic [31:0] p, input logic rd, input logic fl,
                     input logic mis, input int bc, input int tc);
    exp_t x;
    x.pc  = p;
    x.rd  = rd;
    x.fl  = fl;
    x.mis = mis;
    x.bc  = CNT_W'(bc);
    x.tc  = CNT_W'(tc);
    exp_q.push_back(x);
    name_q.push_back(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    idle();
    @(negedge clk);
    cyc("reset", 32'h0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("run1", 32'h4, 0, 0, 0, 0, 0);
    cyc("run2", 32'h8, 0, 0, 0, 0, 0);
    cyc("run3", 32'hC, 0, 0, 0, 0, 0);

    // Not-taken branch counts; non-branch with stale bc_out does nothing.
    set_ex(1, 1, 0, 0, 0, 32'h50, 32'h40, 32'h0);
    cyc("br_not_taken", 32'h10, 0, 0, 0, 1, 0);
    set_ex(1, 0, 0, 0, 1, 32'h54, 32'h40, 32'h0);
    cyc("non_branch_bc1", 32'h14, 0, 0, 0, 1, 0);
    idle();
    stall = 1'b1;
    cyc("run_stall", 32'h14, 0, 0, 0, 1, 0);
    stall = 1'b0;

    // BEQ taken, then a jal held during FLUSH that must be ignored.
    set_ex(1, 1, 0, 0, 1, 32'h100, 32'h40, 32'h0);
    cyc("beq_taken", 32'h140, 1, 1, 0, 2, 1);
    set_ex(1, 0, 1, 0, 0, 32'h300, 32'h20, 32'h0);
    cyc("flush1_ignore", 32'h144, 0, 1, 0, 2, 1);
    cyc("flush2_end", 32'h148, 0, 0, 0, 2, 1);
    idle();
    cyc("after_flush", 32'h14C, 0, 0, 0, 2, 1);

    // JALR under stall: redirect wins, flush counter keeps running through stall.
    stall = 1'b1;
    set_ex(1, 1, 0, 1, 0, 32'h0, 32'h10, 32'h2001);
    cyc("jalr_stall", 32'h2010, 1, 1, 0, 2, 1);
    idle();
    cyc("jalr_fl1_stall", 32'h2010, 0, 1, 0, 2, 1);
    cyc("jalr_fl2_stall", 32'h2010, 0, 0, 0, 2, 1);
    stall = 1'b0;
    cyc("jalr_resume", 32'h2014, 0, 0, 0, 2, 1);

    // JAL (with branch flag also set) to top of address space, then pc wraps.
    set_ex(1, 1, 1, 0, 1, 32'h10, 32'hFFFF_FFEC, 32'h0);
    cyc("jal_top", 32'hFFFF_FFFC, 1, 1, 0, 2, 1);
    idle();
    cyc("pc_wrap", 32'h0, 0, 1, 0, 2, 1);
    cyc("pc_wrap_next", 32'h4, 0, 0, 0, 2, 1);

    // Branch counter saturation.
    for (int k = 0; k < 14; k++) begin
      set_ex(1, 1, 0, 0, 0, 32'h0, 32'h40, 32'h0);
      cyc($sformatf("bcnt_sat%0d", k), 32'(8 + 4 * k), 0, 0, 0, (3 + k > 15) ? 15 : 3 + k, 1);
    end

    // Taken counter saturation; each taken branch costs a redirect plus two flush cycles.
    for (int j = 0; j < 15; j++) begin
      set_ex(1, 1, 0, 0, 1, 32'h1000, 32'h0, 32'h0);
      cyc($sformatf("tcnt_sat%0d", j), 32'h1000, 1, 1, 0, 15, (2 + j > 15) ? 15 : 2 + j);
      idle();
      cyc($sformatf("tcnt_fl%0d", j), 32'h1004, 0, 1, 0, 15, (2 + j > 15) ? 15 : 2 + j);
      cyc($sformatf("tcnt_end%0d", j), 32'h1008, 0, 0, 0, 15, (2 + j > 15) ? 15 : 2 + j);
    end

    // Misaligned JAL traps; TRAP ignores further takes and holds pc.
    set_ex(1, 0, 1, 0, 0, 32'h100, 32'h6, 32'h0);
    cyc("misalign", 32'h1008, 0, 1, 1, 15, 15);
    set_ex(1, 0, 1, 0, 0, 32'h100, 32'h0, 32'h0);
    cyc("trap_take_ign", 32'h1008, 0, 1, 1, 15, 15);
    idle();
    cyc("trap_hold", 32'h1008, 0, 1, 1, 15, 15);
    rst = 1'b1;
    cyc("trap_rst", 32'h0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Reset in the middle of a flush.
    set_ex(1, 0, 1, 0, 0, 32'h200, 32'h0, 32'h0);
    cyc("jal_pre_rst", 32'h200, 1, 1, 0, 0, 0);
    idle();
    rst = 1'b1;
    cyc("flush_rst", 32'h0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("post_rst", 32'h4, 0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
